opendap_swd_link_ctrl: RTL and testbench
========================================

OPENDAP_SWD_LINK_CTRL -- requirements
Module: opendap_swd_link_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first; reset rst_n, asynchronous, active-low; clock swclk:
 swclk  in  1  SWD clock, all state on posedge
 rst_n  in  1  asynchronous active-low reset
 exit_dormant  in  1  pulse: Dormant-to-SWD select seen
 enter_dormant  in  1  pulse: SWD-to-Dormant select seen
 line_reset  in  1  level: >=50 consecutive SWDIO highs in progress
 hdr_valid  in  1  pulse: serial engine has a packet header this cycle
 hdr_apndp  in  1  header APnDP
 hdr_rnw  in  1  header RnW
 hdr_addr  in  2  header A[3:2]
 hdr_parity_ok  in  1  header parity correct
 tsel_valid  in  1  pulse: TARGETSEL data phase complete
 tsel_match  in  1  TARGETSEL data equals this target's ID
 link_state  out  3  current state encoding
 phy_en  out  1  serial engine enabled
 resp_en  out  1  engine may drive ACK for current header
 link_up  out  1  one-cycle pulse on entry to ACTIVE
 lockout  out  1  target deselected by TARGETSEL

Function
REQ-002 SHALL implement states DORMANT=0, RESET_WAIT=1, ACTIVE=2, LOCKOUT=3; other encodings SHALL return to DORMANT next cycle.
REQ-003 All inputs SHALL be sampled on posedge swclk; transitions SHALL take effect on the following edge.
REQ-004 Event priority per cycle: enter_dormant > line_reset > tsel_valid > hdr_valid.
REQ-005 DORMANT: exit_dormant -> RESET_WAIT; line_reset, hdr_valid and tsel_valid SHALL be ignored.
REQ-006 RESET_WAIT, ACTIVE, LOCKOUT: enter_dormant -> DORMANT.
REQ-007 ACTIVE or LOCKOUT: line_reset high -> RESET_WAIT; RESET_WAIT with line_reset high SHALL stay in RESET_WAIT.
REQ-008 RESET_WAIT: hdr_valid && hdr_parity_ok && !hdr_apndp && hdr_rnw && hdr_addr==0 (DPIDR read) -> ACTIVE, link_up=1 for that cycle.
REQ-009 RESET_WAIT: any other valid header SHALL cause no transition and resp_en=0.
REQ-010 tsel_valid with tsel_match=0 in RESET_WAIT or ACTIVE -> LOCKOUT; tsel_match=1 SHALL cause no transition.
REQ-011 LOCKOUT: headers and tsel_valid ignored; resp_en=0.
REQ-012 resp_en SHALL be combinational: hdr_valid && hdr_parity_ok && (state==ACTIVE || (state==RESET_WAIT && DPIDR read)).
REQ-013 phy_en SHALL be 1 in every state except DORMANT; lockout SHALL be 1 iff state==LOCKOUT.
REQ-014 exit_dormant outside DORMANT SHALL be ignored.
REQ-015 Header with hdr_parity_ok=0 SHALL cause no transition and resp_en=0 in every state.

Reset
REQ-016 On rst_n low: state=DORMANT; link_state=0, phy_en=0, resp_en=0, link_up=0, lockout=0.
REQ-017 Reset assertion mid-packet SHALL abandon the packet with no output glitch beyond REQ-016 values.

Configuration
REQ-018 Macro OPENDAP_SWD_MULTIDROP_EN defined: TARGETSEL handling and LOCKOUT per REQ-010/011.
REQ-019 Macro undefined: tsel_valid/tsel_match ignored, LOCKOUT unreachable, lockout tied 0; all other behaviour identical.

Structure
REQ-020 State encodings, DPIDR address constant and state width SHALL live in shared package opendap_swd_pkg.
REQ-021 Single flat module, no sub-modules; DPIDR-read header decode SHALL be one named combinational term reused by REQ-008 and REQ-012.

Verification
REQ-022 Reset -> exit_dormant -> line_reset 50 cycles -> DPIDR read header: states 0->1->2, link_up one pulse, resp_en=1 on the header.
REQ-023 In RESET_WAIT send AP read (apndp=1, addr=1): resp_en=0, state stays 1; then DPIDR read -> state 2.
REQ-024 ACTIVE, assert enter_dormant and line_reset same cycle: next state DORMANT, phy_en=0.
REQ-025 MULTIDROP_EN: RESET_WAIT, tsel_valid match=0 -> LOCKOUT, lockout=1, DPIDR read gives resp_en=0; line_reset -> RESET_WAIT.
REQ-026 Without MULTIDROP_EN: same TARGETSEL stimulus -> state unchanged, lockout=0.
REQ-027 DORMANT, hdr_valid DPIDR read and line_reset: state stays 0, resp_en=0; bad parity in ACTIVE: resp_en=0.

Source files
------------

// File: rtl/opendap_swd_pkg.sv
// Shared SWD link definitions: link state encodings, state width and the DPIDR address.
package opendap_swd_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_DORMANT    = 3'd0,
      ST_RESET_WAIT = 3'd1,
      ST_ACTIVE     = 3'd2,
      ST_LOCKOUT    = 3'd3
   } link_state_e;

   localparam logic [1:0] DPIDR_ADDR = 2'b00;

endpackage

// File: rtl/opendap_swd_link_ctrl.sv
// SWD link-layer controller: dormant/line-reset/DPIDR bring-up sequencing for the serial engine.
// Define OPENDAP_SWD_MULTIDROP_EN to enable TARGETSEL handling and the LOCKOUT state.
module opendap_swd_link_ctrl (
   input  logic       swclk,
   input  logic       rst_n,
   input  logic       exit_dormant,
   input  logic       enter_dormant,
   input  logic       line_reset,
   input  logic       hdr_valid,
   input  logic       hdr_apndp,
   input  logic       hdr_rnw,
   input  logic [1:0] hdr_addr,
   input  logic       hdr_parity_ok,
   input  logic       tsel_valid,
   input  logic       tsel_match,
   output logic [2:0] link_state,
   output logic       phy_en,
   output logic       resp_en,
   output logic       link_up,
   output logic       lockout
);
   import opendap_swd_pkg::*;

   link_state_e state_q, state_d;
   logic        dpidr_rd;
   logic        tsel_evt;
   logic        tsel_nomatch;

   // Only a clean DP read of DPIDR may bring the link up out of RESET_WAIT.
   assign dpidr_rd = hdr_valid && hdr_parity_ok && !hdr_apndp && hdr_rnw &&
                     (hdr_addr == DPIDR_ADDR);

`ifdef OPENDAP_SWD_MULTIDROP_EN
   assign tsel_evt     = tsel_valid;
   assign tsel_nomatch = tsel_valid && !tsel_match;
`else
   logic tsel_unused;
   assign tsel_unused  = tsel_valid | tsel_match;
   assign tsel_evt     = 1'b0;
   assign tsel_nomatch = 1'b0;
`endif

   always_ff @(posedge swclk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_DORMANT;
      else        state_q <= state_d;
   end

   // Branch order within each state encodes enter_dormant > line_reset > tsel_valid > hdr_valid.
   always_comb begin
      state_d = state_q;
      link_up = 1'b0;
      case (state_q)
         ST_DORMANT: begin
            if (exit_dormant) state_d = ST_RESET_WAIT;
         end
         ST_RESET_WAIT: begin
            if (enter_dormant)      state_d = ST_DORMANT;
            else if (line_reset)    state_d = ST_RESET_WAIT;
            else if (tsel_nomatch)  state_d = ST_LOCKOUT;
            else if (!tsel_evt && dpidr_rd) begin
               state_d = ST_ACTIVE;
               link_up = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (enter_dormant)      state_d = ST_DORMANT;
            else if (line_reset)    state_d = ST_RESET_WAIT;
            else if (tsel_nomatch)  state_d = ST_LOCKOUT;
         end
         ST_LOCKOUT: begin
            if (enter_dormant)      state_d = ST_DORMANT;
            else if (line_reset)    state_d = ST_RESET_WAIT;
         end
         default: state_d = ST_DORMANT;
      endcase
   end

   assign link_state = state_q;
   assign phy_en     = (state_q != ST_DORMANT);
   assign resp_en    = hdr_valid && hdr_parity_ok &&
                       ((state_q == ST_ACTIVE) || ((state_q == ST_RESET_WAIT) && dpidr_rd));

`ifdef OPENDAP_SWD_MULTIDROP_EN
   assign lockout = (state_q == ST_LOCKOUT);
`else
   assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_opendap_swd_link_ctrl.sv
// Self-checking bench for opendap_swd_link_ctrl: directed bring-up scenarios plus randomized traffic
// against a rule-level reference model. Honours OPENDAP_SWD_MULTIDROP_EN if defined.
module tb_opendap_swd_link_ctrl;

`ifdef OPENDAP_SWD_MULTIDROP_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic       swclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       exit_dormant = 1'b0, enter_dormant = 1'b0, line_reset = 1'b0;
   logic       hdr_valid = 1'b0, hdr_apndp = 1'b0, hdr_rnw = 1'b0, hdr_parity_ok = 1'b0;
   logic [1:0] hdr_addr = 2'b00;
   logic       tsel_valid = 1'b0, tsel_match = 1'b0;
   logic [2:0] link_state;
   logic       phy_en, resp_en, link_up, lockout;

   int checks = 0;
   int failures = 0;
   int m_state = 0;

   opendap_swd_link_ctrl dut (
      .swclk(swclk), .rst_n(rst_n),
      .exit_dormant(exit_dormant), .enter_dormant(enter_dormant), .line_reset(line_reset),
      .hdr_valid(hdr_valid), .hdr_apndp(hdr_apndp), .hdr_rnw(hdr_rnw), .hdr_addr(hdr_addr),
      .hdr_parity_ok(hdr_parity_ok), .tsel_valid(tsel_valid), .tsel_match(tsel_match),
      .link_state(link_state), .phy_en(phy_en), .resp_en(resp_en),
      .link_up(link_up), .lockout(lockout)
   );

   always #5 swclk = ~swclk;

   // ---------------- reference model (state numbers: 0 dormant, 1 reset-wait, 2 active, 3 lockout)
   function automatic bit is_dpidr_read();
      return hdr_valid && hdr_parity_ok && !hdr_apndp && hdr_rnw && (hdr_addr == 2'd0);
   endfunction

   function automatic int model_next(int s);
      if (s == 0) return exit_dormant ? 1 : 0;
      if (enter_dormant) return 0;
      if (line_reset) return 1;
      if (MD && tsel_valid) begin
         if (s != 3 && !tsel_match) return 3;
         return s;
      end
      if (s == 1 && is_dpidr_read()) return 2;
      return s;
   endfunction

   function automatic bit model_resp(int s);
      return hdr_valid && hdr_parity_ok && (s == 2 || (s == 1 && is_dpidr_read()));
   endfunction

   function automatic bit model_link_up(int s);
      return (s == 1) && (model_next(s) == 2);
   endfunction

   // ---------------- driver tasks
   task automatic drive(input logic xd, input logic ed, input logic lr, input logic hv,
                        input logic ap, input logic rw, input logic [1:0] a, input logic pok,
                        input logic tv, input logic tm);
      @(negedge swclk);
      exit_dormant = xd; enter_dormant = ed; line_reset = lr;
      hdr_valid = hv; hdr_apndp = ap; hdr_rnw = rw; hdr_addr = a; hdr_parity_ok = pok;
      tsel_valid = tv; tsel_match = tm;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
   endtask

   task automatic dpidr_hdr();
      drive(0, 0, 0, 1, 0, 1, 2'd0, 1, 0, 0);
   endtask

   task automatic advance();
      int n;
      n = model_next(m_state);
      @(posedge swclk);
      m_state = n;
   endtask

   task automatic do_reset();
      @(negedge swclk);
      rst_n = 1'b0;
      #1;
      m_state = 0;
      @(negedge swclk);
      rst_n = 1'b1;
   endtask

   // Reset, exit_dormant, line reset and DPIDR read: the normal bring-up path to ACTIVE.
   task automatic bring_up();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      for (int i = 0; i < 50; i++) begin
         drive(0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      end
      dpidr_hdr(); advance();
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 1, 1, 1, 0, 1, 2'd0, 1, 1, 0);
      checks++;
      if (link_state !== 3'd0 || phy_en !== 1'b0 || resp_en !== 1'b0 || link_up !== 1'b0 || lockout !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: state=%0d phy=%b resp=%b up=%b lock=%b required 0/0/0/0/0",
                  link_state, phy_en, resp_en, link_up, lockout);
      end
      // Asynchronous reset asserted while an ACTIVE header is being answered.
      bring_up();
      drive(0, 0, 0, 1, 1, 0, 2'd1, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      m_state = 0;
      checks++;
      if (link_state !== 3'd0 || resp_en !== 1'b0 || phy_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_midpacket: state=%0d resp=%b phy=%b required 0/0/0", link_state, resp_en, phy_en);
      end
      @(negedge swclk);
      rst_n = 1'b1;
   endtask

   task automatic test_bring_up();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
      checks++;
      if (link_state !== 3'd0 || phy_en !== 1'b0) begin
         failures++; $display("FAIL bringup_dormant: state=%0d phy=%b required 0/0", link_state, phy_en);
      end
      advance();
      for (int i = 0; i < 50; i++) begin
         drive(0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0);
         checks++;
         if (link_state !== 3'd1 || phy_en !== 1'b1) begin
            failures++; $display("FAIL bringup_linereset[%0d]: state=%0d phy=%b required 1/1", i, link_state, phy_en);
         end
         advance();
      end
      dpidr_hdr();
      checks++;
      if (resp_en !== 1'b1 || link_up !== 1'b1 || link_state !== 3'd1) begin
         failures++; $display("FAIL bringup_dpidr: resp=%b up=%b state=%0d required 1/1/1", resp_en, link_up, link_state);
      end
      advance();
      idle();
      checks++;
      if (link_state !== 3'd2 || link_up !== 1'b0) begin
         failures++; $display("FAIL bringup_active: state=%0d up=%b required 2/0", link_state, link_up);
      end
   endtask

   task automatic test_rw_ap_read();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      drive(0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      drive(0, 0, 0, 1, 1, 1, 2'd1, 1, 0, 0);
      checks++;
      if (resp_en !== 1'b0 || link_up !== 1'b0) begin
         failures++; $display("FAIL rw_ap_read_resp: resp=%b up=%b required 0/0", resp_en, link_up);
      end
      advance();
      dpidr_hdr();
      checks++;
      if (link_state !== 3'd1 || resp_en !== 1'b1) begin
         failures++; $display("FAIL rw_ap_read_stay: state=%0d resp=%b required 1/1", link_state, resp_en);
      end
      advance();
      idle();
      checks++;
      if (link_state !== 3'd2) begin
         failures++; $display("FAIL rw_then_dpidr: state=%0d required 2", link_state);
      end
   endtask

   task automatic test_dormant_priority();
      bring_up();
      drive(0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      idle();
      checks++;
      if (link_state !== 3'd0 || phy_en !== 1'b0) begin
         failures++; $display("FAIL dormant_priority: state=%0d phy=%b required 0/0", link_state, phy_en);
      end
      // Line reset and headers are ignored while dormant.
      drive(0, 0, 1, 1, 0, 1, 2'd0, 1, 0, 0);
      checks++;
      if (resp_en !== 1'b0 || link_up !== 1'b0) begin
         failures++; $display("FAIL dormant_hdr_resp: resp=%b up=%b required 0/0", resp_en, link_up);
      end
      advance();
      idle();
      checks++;
      if (link_state !== 3'd0) begin
         failures++; $display("FAIL dormant_ignore: state=%0d required 0", link_state);
      end
   endtask

   task automatic test_bad_parity();
      bring_up();
      drive(0, 0, 0, 1, 1, 1, 2'd2, 0, 0, 0);
      checks++;
      if (resp_en !== 1'b0) begin
         failures++; $display("FAIL active_bad_parity: resp=%b required 0", resp_en);
      end
      advance();
      drive(0, 0, 0, 1, 1, 0, 2'd3, 1, 0, 0);
      checks++;
      if (resp_en !== 1'b1 || link_state !== 3'd2) begin
         failures++; $display("FAIL active_good_hdr: resp=%b state=%0d required 1/2", resp_en, link_state);
      end
      advance();
   endtask

   task automatic test_targetsel();
      int exp_s;
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0); advance();
      exp_s = MD ? 3 : 1;
      dpidr_hdr();
      checks++;
      if (link_state !== exp_s[2:0] || lockout !== MD || resp_en !== !MD) begin
         failures++;
         $display("FAIL tsel_nomatch: state=%0d lock=%b resp=%b required %0d/%b/%b",
                  link_state, lockout, resp_en, exp_s, MD, !MD);
      end
      advance();
      drive(0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0); advance();
      idle();
      checks++;
      if (link_state !== 3'd1 || lockout !== 1'b0) begin
         failures++; $display("FAIL tsel_linereset: state=%0d lock=%b required 1/0", link_state, lockout);
      end
      drive(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1); advance();
      idle();
      checks++;
      if (link_state !== 3'd1) begin
         failures++; $display("FAIL tsel_match: state=%0d required 1", link_state);
      end
   endtask

   task automatic test_random();
      logic xd, ed, lr, hv, ap, rw, pok, tv, tm;
      logic [1:0] a;
      bit exp_resp, exp_up;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         xd = ($urandom_range(0, 99) < 20);
         ed = ($urandom_range(0, 99) < 4);
         lr = ($urandom_range(0, 99) < 8);
         hv = ($urandom_range(0, 99) < 45);
         if ($urandom_range(0, 1) == 1) begin
            ap = 1'b0; rw = 1'b1; a = 2'd0;
         end else begin
            ap = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1)); a = 2'($urandom_range(0, 3));
         end
         pok = ($urandom_range(0, 99) < 85);
         tv = ($urandom_range(0, 99) < 10);
         tm = 1'($urandom_range(0, 1));
         drive(xd, ed, lr, hv, ap, rw, a, pok, tv, tm);
         exp_resp = model_resp(m_state);
         exp_up = model_link_up(m_state);
         checks++;
         if (link_state !== m_state[2:0] || resp_en !== exp_resp || link_up !== exp_up ||
             phy_en !== (m_state != 0) || lockout !== (m_state == 3)) begin
            failures++;
            $display("FAIL random[%0d]: state=%0d resp=%b up=%b phy=%b lock=%b required %0d/%b/%b/%b/%b",
                     i, link_state, resp_en, link_up, phy_en, lockout,
                     m_state, exp_resp, exp_up, (m_state != 0), (m_state == 3));
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_bring_up();
      test_rw_ap_read();
      test_dormant_priority();
      test_bad_parity();
      test_targetsel();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
